// File: rtl/core_pkg.sv
// Shared core definitions: branch_ctrl select encodings, fetch FSM states, datapath width.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        pc_4       = 2'b00,
        pc_imm     = 2'b01,
        pc_imm_sr1 = 2'b10
    } branch_sel_t;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/if_stage_next_pc_gen.sv
// Redirect decode: turns the branch_ctrl select into taken plus the redirect target.
// Purely combinational; 2'b11 falls through to sequential fetch.
module next_pc_gen #(
    parameter int XLEN = 32
) (
    input  logic [1:0]      branch_ctrl,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            taken,
    output logic [XLEN-1:0] target
);
    import core_pkg::*;

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = ex_rs1 + ex_imm;

    always_comb begin
        taken  = 1'b0;
        target = ex_pc + ex_imm;
        case (branch_ctrl)
            pc_imm:     taken = 1'b1;
            pc_imm_sr1: begin
                taken  = 1'b1;
                target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues single-outstanding fetches and fills IF/ID.
// A one-entry hold buffer catches a response that lands while ID is stalled.
module if_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      branch_ctrl,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            stall,
    output logic            im_req,
    output logic [XLEN-1:0] im_addr,
    input  logic            im_rvalid,
    input  logic [31:0]     im_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_inst,
    output logic            flush
);
    import core_pkg::*;

    fetch_state_t    state;
    logic            taken;
    logic            accept;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next4;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_inst;

    next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
        .branch_ctrl (branch_ctrl),
        .ex_pc       (ex_pc),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .taken       (taken),
        .target      (target)
    );

    assign flush    = taken;
    assign pc_next4 = pc + XLEN'(4);
    assign accept   = !if_id_valid || !stall;

    // A response consumed in WAIT immediately chains the next request at pc+4.
    always_comb begin
        im_req  = 1'b0;
        im_addr = pc;
        if (!rst) begin
            case (state)
                REQ:  im_req = !taken;
                WAIT: if (!taken && im_rvalid && accept) begin
                    im_req  = 1'b1;
                    im_addr = pc_next4;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_inst  <= '0;
            buf_pc      <= '0;
            buf_inst    <= '0;
        end else begin
            // ID drained (or redirected) with nothing new: leave a bubble.
            if (taken || !stall)
                if_id_valid <= 1'b0;
            case (state)
                REQ: begin
                    if (taken) pc <= target;
                    else       state <= WAIT;
                end
                WAIT: begin
                    if (taken) begin
                        pc    <= target;
                        state <= im_rvalid ? REQ : DROP;
                    end else if (im_rvalid) begin
                        pc <= pc_next4;
                        if (accept) begin
                            if_id_valid <= 1'b1;
                            if_id_pc    <= pc;
                            if_id_inst  <= im_rdata;
                        end else begin
                            buf_pc   <= pc;
                            buf_inst <= im_rdata;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (taken) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= buf_pc;
                        if_id_inst  <= buf_inst;
                        state       <= REQ;
                    end
                end
                DROP: begin
                    // Stale response retires the old request even if another redirect lands now.
                    if (taken)     pc <= target;
                    if (im_rvalid) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V core, directly downstream of `branch_ctrl`. It owns the PC register and turns the 2-bit `branch_ctrl` select into the next fetch address. It drives a single-outstanding request/response instruction-memory port and fills the IF/ID pipeline register. A one-entry hold buffer absorbs responses that arrive while ID is stalled.

## Interface
Parameters:
- `XLEN`, 32, datapath / address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `branch_ctrl`  in  2  from `branch_ctrl`: 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1, 11 treated as 00
- `ex_pc`  in  XLEN  PC of the instruction in EX
- `ex_imm`  in  XLEN  sign-extended immediate of that instruction
- `ex_rs1`  in  XLEN  forwarded rs1 value of that instruction
- `stall`  in  1  hazard unit: hold IF/ID contents
- `im_req`  out  1  single-cycle fetch request pulse
- `im_addr`  out  XLEN  fetch address, valid when `im_req`
- `im_rvalid`  in  1  response valid, at least 1 cycle after `im_req`
- `im_rdata`  in  32  fetched instruction
- `if_id_valid`  out  1  IF/ID register holds a live instruction
- `if_id_pc`  out  XLEN  PC of that instruction
- `if_id_inst`  out  32  the instruction
- `flush`  out  1  combinational; equals `taken`; drives the flush of ID/EX

## Operation
- `taken` = (`branch_ctrl` == 01 || `branch_ctrl` == 10). `target` = `ex_pc`+`ex_imm` for 01, and (`ex_rs1`+`ex_imm`) with bit 0 cleared for 10. Additions wrap modulo 2^XLEN.
- `pc` register: address of the outstanding fetch or the next fetch to issue.
- `accept` = !`if_id_valid` || !`stall`.
- FSM states:
  - REQ: `im_req`=!`taken`, `im_addr`=`pc`. Next state is WAIT if !`taken`; otherwise stay in REQ with `pc`<=`target`.
  - WAIT (request outstanding):
    - `taken`: `pc`<=`target`; next state is REQ if `im_rvalid`, otherwise DROP.
    - `im_rvalid` && `accept`: IF/ID<={1,`pc`,`im_rdata`}; `pc`<=`pc`+4; issue the next request the same cycle (`im_req`=1, `im_addr`=`pc`+4); stay in WAIT.
    - `im_rvalid` && !`accept`: buffer<={`pc`,`im_rdata`}; `pc`<=`pc`+4; go to HOLD.
  - HOLD:
    - `taken`: discard the buffer; `pc`<=`target`; go to REQ.
    - Else if !`stall`: IF/ID<=buffer; go to REQ.
  - DROP (stale response pending):
    - `taken`: `pc`<=`target`; stay in DROP.
    - `im_rvalid`: discard the data; go to REQ.
- `taken` always clears `if_id_valid` at the next edge, regardless of `stall`. Redirect has priority over stall and over capture.
- When `stall` && `if_id_valid` && no `taken`, IF/ID holds its value.
- `im_req` is forced to 0 while `rst` is high.

## Timing
- Reset values: state=REQ, `pc`=`RESET_PC`, `if_id_valid`=0, `if_id_pc`=0, `if_id_inst`=0, buffer=0, `im_req`=0.
- The first `im_req` is issued in the first cycle after `rst` deasserts.
- With 1-cycle memory latency:
  - Steady-state throughput is one instruction per cycle.
  - Fetch-to-IF/ID latency is 1 cycle after `im_rvalid`.
- Redirect penalty:
  - `taken` in cycle N sets `pc`=`target` at edge N+1.
  - The request to `target` is issued in cycle N+1 from REQ, or after the stale response from DROP.
- `im_rvalid` must never arrive in REQ or HOLD. The bench asserts this.
- `rst` asserted mid-fetch abandons the outstanding request. The memory model must drop it as well.

## Structure
- Shared package `core_pkg`:
  - `branch_ctrl` encodings `pc_4`=2'b00, `pc_imm`=2'b01, `pc_imm_sr1`=2'b10 (shared with `branch_ctrl`).
  - Fetch FSM enum {REQ, WAIT, HOLD, DROP}.
  - `XLEN`.
- One sub-module, `next_pc_gen`: combinational; computes `taken` and `target` from `branch_ctrl`, `ex_pc`, `ex_imm`, `ex_rs1`.

## Test plan
- Reset release, 1-cycle memory returning addr as data: `im_addr` sequence is 0x0, 0x4, 0x8. `if_id_inst` follows one cycle behind, with `if_id_pc` matching.
- `stall` held 3 cycles with IF/ID full and a response arriving: FSM enters HOLD. No `im_req` during the stall. After release, IF/ID gets the buffered instruction, then fetch resumes at the next address.
- `branch_ctrl`=01, `ex_pc`=0x100, `ex_imm`=0x20 while WAIT with no response: FSM goes to DROP and `if_id_valid`=0. The stale response is discarded. The next `im_addr`=0x120.
- `branch_ctrl`=10, `ex_rs1`=0x203, `ex_imm`=0x4: the next `im_addr`=0x206 (bit 0 cleared), and `flush`=1 for that one cycle.
- `taken` together with `stall`=1 and `im_rvalid`=1 in the same cycle: IF/ID is flushed, the response is dropped, and `im_addr`=`target` in the following cycle.
- `branch_ctrl`=11 and `ex_imm`=0xFFFF_FFFC with `ex_pc`=0x0 under `branch_ctrl`=01: 11 is treated as pc+4. 01 wraps to `target` 0xFFFF_FFFC.
